// File: rtl/flitzip_pkg.sv
// Shared constants, header struct and delta-fit helper for the flit compression link.
// Used by flit_delta_packer and delta_bitpacker.
package flitzip_pkg;

  localparam int INPUT_WIDTH = 128;
  localparam int CHUNK_SIZE  = 8;
  localparam int NUM_CHUNKS  = INPUT_WIDTH / CHUNK_SIZE;
  localparam int EN_BITS     = 3;
  localparam int LEN_BITS    = $clog2(INPUT_WIDTH) + 1;
  localparam int DELTA_BITS  = CHUNK_SIZE + 1;
  localparam int DW_BITS     = 4;
  localparam int MIN_DW      = 2;
  localparam int MAX_DW      = (1 << EN_BITS) + 1;

  localparam logic [EN_BITS-1:0] EN_RAW        = 3'b111;
  localparam logic [EN_BITS-1:0] RAW_EN_THRESH = 3'd6;

  typedef logic signed [DELTA_BITS-1:0] delta_t;

  typedef struct packed {
    logic [CHUNK_SIZE-1:0] base;
    logic [EN_BITS-1:0]    en;
    logic                  raw;
    logic [LEN_BITS-1:0]   len;
  } hdr_t;

  // A delta fits in dw signed bits when every bit above dw-1 equals the sign bit.
  function automatic logic delta_fits(input delta_t d, input logic [DW_BITS-1:0] dw);
    delta_t sh;
    sh = d >>> (dw - DW_BITS'(1));
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/delta_bitpacker.sv
// Combinational packer: places each delta, truncated to dw bits, at payload[i*dw +: dw].
// One candidate layout per legal width is built statically and dw selects among them.
module delta_bitpacker
  import flitzip_pkg::*;
(
  input  logic [NUM_CHUNKS-1:0][DELTA_BITS-1:0] deltas,
  input  logic [DW_BITS-1:0]                    dw,
  output logic [INPUT_WIDTH-1:0]                payload
);

  logic [INPUT_WIDTH-1:0] cand [MIN_DW:MAX_DW];

  for (genvar wi = MIN_DW; wi <= MAX_DW; wi++) begin : g_width
    logic [NUM_CHUNKS*wi-1:0] dense;
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
      assign dense[gi*wi +: wi] = deltas[gi][wi-1:0];
    end
    // Widths above the compressible range overflow the flit; the raw path never uses them.
    assign cand[wi] = INPUT_WIDTH'(dense);
  end

  always_comb begin
    payload = '0;
    for (int w = MIN_DW; w <= MAX_DW; w++) begin
      if (dw == DW_BITS'(w)) begin
        payload = cand[w];
      end
    end
  end

endmodule

// File: rtl/flit_delta_packer.sv
// Two-stage valid/ready delta packer: S1 computes deltas and the fit decision, S2 packs.
// Define FLITZIP_STATS_EN to add compressed/raw/bits-saved counters with a sync clear.
module flit_delta_packer
  import flitzip_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] data_in,
  input  logic [CHUNK_SIZE-1:0]  base_in,
  input  logic [EN_BITS-1:0]     en_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] payload_out,
  output logic [CHUNK_SIZE-1:0]  base_out,
  output logic [EN_BITS-1:0]     en_out,
  output logic                   raw_out,
  output logic [LEN_BITS-1:0]    len_out
`ifdef FLITZIP_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [31:0]            stat_comp_cnt,
  output logic [31:0]            stat_raw_cnt,
  output logic [31:0]            stat_bits_saved
`endif
);

  logic s1_load, s2_load;

  logic [NUM_CHUNKS-1:0][DELTA_BITS-1:0] delta_c;
  logic [NUM_CHUNKS-1:0]                 fit_c;
  logic [DW_BITS-1:0]                    dw_in;
  logic                                  comp_c;

  logic                                  s1_valid_q, s1_valid_d;
  logic [NUM_CHUNKS-1:0][DELTA_BITS-1:0] s1_delta_q, s1_delta_d;
  logic                                  s1_comp_q, s1_comp_d;
  logic [CHUNK_SIZE-1:0]                 s1_base_q, s1_base_d;
  logic [EN_BITS-1:0]                    s1_en_q, s1_en_d;
  logic [INPUT_WIDTH-1:0]                s1_data_q, s1_data_d;

  logic [DW_BITS-1:0]     s1_dw;
  logic [INPUT_WIDTH-1:0] packed_c;

  logic                   s2_valid_q, s2_valid_d;
  logic [INPUT_WIDTH-1:0] s2_payload_q, s2_payload_d;
  hdr_t                   s2_hdr_q, s2_hdr_d;

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  assign dw_in = DW_BITS'(en_in) + DW_BITS'(MIN_DW);

  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_delta
    assign delta_c[gi] = {1'b0, data_in[gi*CHUNK_SIZE +: CHUNK_SIZE]} - {1'b0, base_in};
    assign fit_c[gi]   = delta_fits(delta_c[gi], dw_in);
  end

  assign comp_c = (en_in < RAW_EN_THRESH) && (&fit_c);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_delta_d = s1_delta_q;
    s1_comp_d  = s1_comp_q;
    s1_base_d  = s1_base_q;
    s1_en_d    = s1_en_q;
    s1_data_d  = s1_data_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_delta_d = delta_c;
      s1_comp_d  = comp_c;
      s1_base_d  = base_in;
      s1_en_d    = en_in;
      s1_data_d  = data_in;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_delta_q <= '0;
      s1_comp_q  <= 1'b0;
      s1_base_q  <= '0;
      s1_en_q    <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_delta_q <= s1_delta_d;
      s1_comp_q  <= s1_comp_d;
      s1_base_q  <= s1_base_d;
      s1_en_q    <= s1_en_d;
      s1_data_q  <= s1_data_d;
    end
  end

  assign s1_dw = DW_BITS'(s1_en_q) + DW_BITS'(MIN_DW);

  delta_bitpacker u_packer (
    .deltas  (s1_delta_q),
    .dw      (s1_dw),
    .payload (packed_c)
  );

  // S2 only changes on a load, which keeps every out_* stable during a stall.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_payload_d = s2_payload_q;
    s2_hdr_d     = s2_hdr_q;
    if (s2_load) begin
      s2_valid_d    = 1'b1;
      s2_hdr_d.base = s1_base_q;
      if (s1_comp_q) begin
        s2_payload_d = packed_c;
        s2_hdr_d.en  = s1_en_q;
        s2_hdr_d.raw = 1'b0;
        s2_hdr_d.len = LEN_BITS'(NUM_CHUNKS) * LEN_BITS'(s1_dw);
      end else begin
        s2_payload_d = s1_data_q;
        s2_hdr_d.en  = EN_RAW;
        s2_hdr_d.raw = 1'b1;
        s2_hdr_d.len = LEN_BITS'(INPUT_WIDTH);
      end
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_payload_q <= '0;
      s2_hdr_q     <= '0;
    end else begin
      s2_valid_q   <= s2_valid_d;
      s2_payload_q <= s2_payload_d;
      s2_hdr_q     <= s2_hdr_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign payload_out = s2_payload_q;
  assign base_out    = s2_hdr_q.base;
  assign en_out      = s2_hdr_q.en;
  assign raw_out     = s2_hdr_q.raw;
  assign len_out     = s2_hdr_q.len;

`ifdef FLITZIP_STATS_EN
  logic        xfer;
  logic [31:0] comp_cnt_q, comp_cnt_d;
  logic [31:0] raw_cnt_q, raw_cnt_d;
  logic [31:0] saved_q, saved_d;

  assign xfer = s2_valid_q && out_ready;

  always_comb begin
    comp_cnt_d = comp_cnt_q;
    raw_cnt_d  = raw_cnt_q;
    saved_d    = saved_q;
    if (stat_clr) begin
      comp_cnt_d = '0;
      raw_cnt_d  = '0;
      saved_d    = '0;
    end else if (xfer) begin
      if (s2_hdr_q.raw) raw_cnt_d = raw_cnt_q + 32'd1;
      else              comp_cnt_d = comp_cnt_q + 32'd1;
      saved_d = saved_q + (32'(INPUT_WIDTH) - 32'(s2_hdr_q.len));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_cnt_q <= '0;
      raw_cnt_q  <= '0;
      saved_q    <= '0;
    end else begin
      comp_cnt_q <= comp_cnt_d;
      raw_cnt_q  <= raw_cnt_d;
      saved_q    <= saved_d;
    end
  end

  assign stat_comp_cnt   = comp_cnt_q;
  assign stat_raw_cnt    = raw_cnt_q;
  assign stat_bits_saved = saved_q;
`endif

endmodule

// File: tb/tb_flit_delta_packer.sv
// Scoreboard bench for flit_delta_packer: directed cases plus randomized flits and back-pressure.
// Expected results come from an arithmetic reference model of the delta/fit/pack rules.
module tb_flit_delta_packer;
  import flitzip_pkg::*;

  typedef struct {
    logic [127:0] payload;
    logic [7:0]   base;
    logic [2:0]   en;
    logic         raw;
    logic [7:0]   len;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [7:0]   base_in = '0;
  logic [2:0]   en_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] payload_out;
  logic [7:0]   base_out;
  logic [2:0]   en_out;
  logic         raw_out;
  logic [7:0]   len_out;
`ifdef FLITZIP_STATS_EN
  logic         stat_clr = 1'b0;
  logic [31:0]  stat_comp_cnt, stat_raw_cnt, stat_bits_saved;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  bit   or_rand = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  longint exp_comp = 0, exp_raw = 0, exp_saved = 0;

  always #5 clk = ~clk;

  flit_delta_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .base_in     (base_in),
    .en_in       (en_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .payload_out (payload_out),
    .base_out    (base_out),
    .en_out      (en_out),
    .raw_out     (raw_out),
    .len_out     (len_out)
`ifdef FLITZIP_STATS_EN
    ,
    .stat_clr        (stat_clr),
    .stat_comp_cnt   (stat_comp_cnt),
    .stat_raw_cnt    (stat_raw_cnt),
    .stat_bits_saved (stat_bits_saved)
`endif
  );

  function automatic exp_t model(input logic [127:0] d, input logic [7:0] b, input logic [2:0] e);
    exp_t r;
    int   dw = int'(e) + 2;
    bit   ok = (e <= 3'd5);
    int   dl [16];
    for (int i = 0; i < 16; i++) begin
      dl[i] = int'(d[i*8 +: 8]) - int'(b);
      if (dl[i] < -(1 << (dw - 1)) || dl[i] > (1 << (dw - 1)) - 1) ok = 1'b0;
    end
    r.base = b;
    if (ok) begin
      r.payload = '0;
      for (int i = 0; i < 16; i++) begin
        logic [127:0] v;
        v = 128'(dl[i] & ((1 << dw) - 1));
        r.payload = r.payload | (v << (i * dw));
      end
      r.en  = e;
      r.raw = 1'b0;
      r.len = 8'(16 * dw);
    end else begin
      r.payload = d;
      r.en      = 3'b111;
      r.raw     = 1'b1;
      r.len     = 8'd128;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs and outputs are sampled on the falling edge, ahead of the rising edge that transfers them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(data_in, base_in, en_in));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 128'(out_valid), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          check("payload", payload_out, mon_e.payload);
          check("base", 128'(base_out), 128'(mon_e.base));
          check("en", 128'(en_out), 128'(mon_e.en));
          check("raw", 128'(raw_out), 128'(mon_e.raw));
          check("len", 128'(len_out), 128'(mon_e.len));
          n_out++;
          if (mon_e.raw) exp_raw++;
          else           exp_comp++;
          exp_saved += 128 - int'(mon_e.len);
          $display("out %0d: raw=%0b en=%0d len=%0d base=%02h payload=%032h",
                   n_out, raw_out, en_out, len_out, base_out, payload_out);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [127:0] d, input logic [7:0] b, input logic [2:0] e);
    int waited = 0;
    data_in  = d;
    base_in  = b;
    en_in    = e;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) check("send_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    or_rand   = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("drain", 128'(sb.size()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef FLITZIP_STATS_EN
  task automatic check_stats();
    check("stat_comp", 128'(stat_comp_cnt), 128'(32'(exp_comp)));
    check("stat_raw", 128'(stat_raw_cnt), 128'(32'(exp_raw)));
    check("stat_saved", 128'(stat_bits_saved), 128'(32'(exp_saved)));
  endtask
`endif

  initial begin
    logic [127:0] d;
    logic [7:0]   b;
    logic [2:0]   e;
    int           k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_payload", payload_out, 128'(0));
    check("rst_len", 128'(len_out), 128'(0));
    check("rst_raw", 128'(raw_out), 128'(0));
    check("rst_en", 128'(en_out), 128'(0));
    check("rst_base", 128'(base_out), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Uniform flit: all deltas zero at the narrowest width.
    send({16{8'h40}}, 8'h40, 3'd0);
    check("latency_early", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    check("latency_valid", 128'(out_valid), 128'(1));
    check("uniform_payload", payload_out, 128'(0));
    check("uniform_len", 128'(len_out), 128'(32));

    // Alternating -2/+2 deltas at 3-bit width.
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = (i % 2 == 0) ? 8'h3E : 8'h42;
    send(d, 8'h40, 3'd1);
    @(posedge clk);
    #1;
    check("alt_payload", payload_out, {80'b0, {8{6'b010110}}});
    check("alt_len", 128'(len_out), 128'(48));

    // Code 6 always falls back to raw.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 8'h11, 3'd6);
    @(posedge clk);
    #1;
    check("en6_raw", 128'(raw_out), 128'(1));
    check("en6_payload", payload_out, d);
    check("en6_en", 128'(en_out), 128'(3'b111));

    // One delta of +5 exceeds the 2-bit range.
    d = {16{8'h40}};
    d[3*8 +: 8] = 8'h45;
    send(d, 8'h40, 3'd0);
    @(posedge clk);
    #1;
    check("nofit_raw", 128'(raw_out), 128'(1));
    check("nofit_len", 128'(len_out), 128'(128));
    drain();

    // Stall: three back-to-back flits against a blocked output.
    out_ready = 1'b0;
    fork
      begin
        for (int n = 0; n < 3; n++) begin
          for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'h80 + 8'(n) + 8'(i % 2);
          send(d, 8'h80, 3'(n));
        end
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        check("stall_in_ready", 128'(in_ready), 128'(0));
        for (int j = 0; j < 3; j++) begin
          check("stall_valid", 128'(out_valid), 128'(1));
          check("stall_payload", payload_out, sb[0].payload);
          check("stall_len", 128'(len_out), 128'(sb[0].len));
          @(negedge clk);
          #1;
        end
        @(posedge clk);
        #1;
        k = n_out;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("stall_burst", 128'(n_out - k), 128'(3));
      end
    join
    drain();

    // Randomized flits with random output back-pressure.
    or_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int mode, r, off;
      b    = 8'($urandom);
      e    = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 2);
      r    = 1 << (int'(e) + 1);
      for (int i = 0; i < 16; i++) begin
        if (mode == 0) begin
          d[i*8 +: 8] = 8'($urandom);
        end else begin
          off = int'($urandom_range(0, 2 * r)) - r;
          if (mode == 2 && off == r) off = r - 1;
          d[i*8 +: 8] = 8'(int'(b) + off);
        end
      end
      send(d, b, e);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

`ifdef FLITZIP_STATS_EN
    check_stats();
`endif

    // Reset with both stages occupied discards everything in flight.
    out_ready = 1'b0;
    send({16{8'h10}}, 8'h10, 3'd0);
    send({16{8'h20}}, 8'h20, 3'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_comp  = 0;
    exp_raw   = 0;
    exp_saved = 0;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'(0));
    check("async_rst_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("post_rst_idle", 128'(out_valid), 128'(0));
    end
`ifdef FLITZIP_STATS_EN
    check_stats();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flit_delta_packer.md
Name: flit_delta_packer

Overview:
- Stage directly downstream of the flit compressor.
- Consumes the input flit, its base value and its 3-bit encoding, and computes per-chunk signed deltas against the base.
- Packs the deltas into a dense payload with a length field, or falls back to raw when compression does not pay.
- Two-stage valid/ready pipeline feeding the link serializer.

Parameters:
- INPUT_WIDTH, 128, flit width in bits.
- CHUNK_SIZE, 8, chunk width in bits.
- EN_BITS, 3, encoding field width.
- NUM_CHUNKS (localparam), INPUT_WIDTH/CHUNK_SIZE = 16.
- LEN_BITS (localparam), $clog2(INPUT_WIDTH)+1 = 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream flit/base/en valid.
- in_ready  out  1  stage can accept.
- data_in  in  INPUT_WIDTH  uncompressed flit.
- base_in  in  CHUNK_SIZE  base value from compressor.
- en_in  in  EN_BITS  delta-width code from compressor.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts.
- payload_out  out  INPUT_WIDTH  packed deltas or raw flit.
- base_out  out  CHUNK_SIZE  base forwarded.
- en_out  out  EN_BITS  code actually used (forced to 3'b111 when raw).
- raw_out  out  1  1 = payload is the uncompressed flit.
- len_out  out  LEN_BITS  valid payload bits.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0; all outputs 0; in_ready=1 after release.
- Delta width: DW = en_in + 2 (2..9). delta_i = chunk_i - base_in, computed 9-bit signed.
- Fit check: every delta_i must lie in [-2^(DW-1), 2^(DW-1)-1].
- Compressed form, used when en_in <= 5 and all deltas fit:
  - delta_i truncated to DW bits, placed at payload[i*DW +: DW], chunk 0 at LSB.
  - Unused upper bits are 0.
  - len_out = NUM_CHUNKS*DW.
  - raw_out=0; en_out=en_in.
- Raw form, used when en_in >= 6 or any delta does not fit: payload_out = data_in, len_out = 128, raw_out=1, en_out=3'b111.
- Pipeline stage S1: on in_valid && in_ready, register the deltas, the fit flag, base and en.
- Pipeline stage S2: shift/pack, then register the outputs.
- Latency: 2 cycles from accept to out_valid with no stalls. Throughput is 1 flit/cycle.
- Handshake:
  - Output transfer happens on out_valid && out_ready.
  - s2 load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational).
- Output stability: while out_valid && !out_ready, all out_* signals hold stable. No flit is dropped or duplicated; order is preserved.
- Simultaneous events: output transfer and S2 reload in the same cycle is allowed. S1 accept and S1 drain in the same cycle is allowed.
- in_valid with in_ready=0: inputs are ignored, and upstream must hold them.
- Reset mid-operation flushes both stages; in-flight flits are discarded.

Optional Feature:
- Macro: FLITZIP_STATS_EN.
- With the macro defined:
  - Adds outputs stat_comp_cnt[31:0] and stat_raw_cnt[31:0], counting compressed and raw flits transferred at the output.
  - Adds stat_bits_saved[31:0], accumulating 128 - len_out per transfer.
  - Adds input stat_clr, a synchronous clear that has priority over increments in the same cycle.
  - Counters wrap at 2^32 and reset to 0 on rst_n.
- Without the macro: these ports and counters do not exist; the datapath is identical.

Decomposition:
- Shared package flitzip_pkg holds:
  - constants INPUT_WIDTH, CHUNK_SIZE, NUM_CHUNKS, EN_BITS, LEN_BITS, EN_RAW=3'b111, RAW_EN_THRESH=6;
  - a packed struct typedef for the header {base, en, raw, len}.
- One natural sub-module: delta_bitpacker, the combinational packer.
  - Inputs: 16×9-bit deltas and DW.
  - Output: 128-bit payload.
  - Instantiated in S2.

Test Plan:
- All chunks 0x40, base 0x40, en 0 → 2 cycles later payload 0, len 32, raw 0, en_out 0.
- Even chunks 0x3E, odd chunks 0x42, base 0x40, en 1 → chunk fields alternate 3'b110/3'b010, low 48 bits = 8 repeats of 6'b010110, upper bits 0, len 48.
- en_in=6 with any data → raw_out 1, payload = data_in, len 128, en_out 3'b111.
- en_in=0, base 0x40, chunk 3 = 0x45 → fit fails → raw_out 1, len 128.
- Three back-to-back flits, out_ready held 0 for 5 cycles:
  - in_ready drops after 2 flits are held;
  - out_* stay stable while stalled;
  - on release, all 3 flits emerge in order on consecutive cycles.
- rst_n pulsed low while both stages are full → out_valid 0 immediately (async); no stale flit appears after release. With FLITZIP_STATS_EN defined, counters read 0.
